// File: rtl/pitch_score_reader.sv
// Pops song/reference pitch FIFOs in lockstep, scores each pair for closeness (0..15)
// and publishes the truncated mean over a 2^WINDOW_LOG2 pair window.
module pitch_score_reader #(
  parameter int TOL_HZ      = 4,
  parameter int STEP_SHIFT  = 2,
  parameter int WINDOW_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        score_en,
  input  logic        song_empty,
  input  logic [14:0] song_dout,
  input  logic        song_valid,
  output logic        song_rd_en,
  input  logic        ref_empty,
  input  logic [14:0] ref_dout,
  input  logic        ref_valid,
  output logic        ref_rd_en,
  output logic [3:0]  sample_score,
  output logic [3:0]  score_avg,
  output logic        score_ready,
  output logic        sync_err
);

  localparam int SUM_W = 4 + WINDOW_LOG2;

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, ACCUM, PUBLISH} state_t;

  state_t                 state, state_next;
  logic [14:0]            song_q, ref_q;
  logic                   got_song, got_ref;
  logic [1:0]             cap_cnt;
  logic [SUM_W-1:0]       sum, sum_next;
  logic [WINDOW_LOG2-1:0] cnt;
  logic                   pair_done, cap_timeout;
  logic [14:0]            diff, pen;
  logic [3:0]             score;

  assign pair_done   = (got_song | song_valid) & (got_ref | ref_valid);
  assign cap_timeout = (cap_cnt == 2'd3);
  assign sum_next    = sum + {{WINDOW_LOG2{1'b0}}, score};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (score_en && !song_empty && !ref_empty) state_next = FETCH;
      FETCH:   state_next = CAPTURE;
      CAPTURE: begin
        if (pair_done)        state_next = ACCUM;
        else if (cap_timeout) state_next = IDLE;
      end
      ACCUM:   state_next = (cnt == '1) ? PUBLISH : IDLE;
      PUBLISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    song_rd_en  = (state == FETCH);
    ref_rd_en   = (state == FETCH);
    score_ready = (state == PUBLISH);
  end

  // Silence overrides the tolerance ladder: 0/0 is a match, a lone 0 is a miss.
  always_comb begin
    diff = (song_q >= ref_q) ? (song_q - ref_q) : (ref_q - song_q);
    pen  = (diff - 15'(TOL_HZ)) >> STEP_SHIFT;
    if ((song_q == '0) || (ref_q == '0))
      score = (song_q == ref_q) ? 4'd15 : 4'd0;
    else if (diff <= 15'(TOL_HZ))
      score = 4'd15;
    else if (pen >= 15'd15)
      score = 4'd0;
    else
      score = 4'd15 - pen[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      song_q       <= '0;
      ref_q        <= '0;
      got_song     <= 1'b0;
      got_ref      <= 1'b0;
      cap_cnt      <= '0;
      sum          <= '0;
      cnt          <= '0;
      sample_score <= '0;
      score_avg    <= '0;
      sync_err     <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          got_song <= 1'b0;
          got_ref  <= 1'b0;
          cap_cnt  <= '0;
        end
        CAPTURE: begin
          if (song_valid && !got_song) begin
            song_q   <= song_dout;
            got_song <= 1'b1;
          end
          if (ref_valid && !got_ref) begin
            ref_q   <= ref_dout;
            got_ref <= 1'b1;
          end
          cap_cnt <= cap_cnt + 2'd1;
          if (!pair_done && cap_timeout) sync_err <= 1'b1;
        end
        ACCUM: begin
          sample_score <= score;
          sum          <= sum_next;
          cnt          <= cnt + 1'b1;
          // Average is loaded on the edge entering PUBLISH so it appears together with score_ready.
          if (cnt == '1) score_avg <= sum_next[WINDOW_LOG2 +: 4];
        end
        PUBLISH: begin
          sum <= '0;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pitch_score_reader.sv
// Directed bench: behavioural FIFOs feed the reader, a scoreboard checks every
// sample_score and every score_avg publication against hand-computed values.
module tb_pitch_score_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        score_en = 1'b0;
  logic        song_empty = 1'b1, ref_empty = 1'b1;
  logic        song_valid = 1'b0, ref_valid = 1'b0;
  logic [14:0] song_dout = '0, ref_dout = '0;
  logic        song_rd_en, ref_rd_en, score_ready, sync_err;
  logic [3:0]  sample_score, score_avg;

  int checks = 0;
  int errors = 0;

  logic [14:0] song_fifo[$];
  logic [14:0] ref_fifo[$];
  int          lag_fifo[$];
  int          exp_sample[$];
  int          exp_avg[$];

  int          rd_song = 0, rd_ref = 0;
  int          s_wait = 0, r_wait = 0;
  logic [14:0] s_hold = '0, r_hold = '0;

  pitch_score_reader #(.TOL_HZ(4), .STEP_SHIFT(2), .WINDOW_LOG2(4)) dut (
    .clk(clk), .rst(rst), .score_en(score_en),
    .song_empty(song_empty), .song_dout(song_dout), .song_valid(song_valid), .song_rd_en(song_rd_en),
    .ref_empty(ref_empty), .ref_dout(ref_dout), .ref_valid(ref_valid), .ref_rd_en(ref_rd_en),
    .sample_score(sample_score), .score_avg(score_avg), .score_ready(score_ready), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // lag = extra cycles before ref data shows up; lag >= 7 pops ref but never raises ref_valid
  task automatic send(input int s, input int r, input int lag, input int exp);
    song_fifo.push_back(15'(s));
    ref_fifo.push_back(15'(r));
    lag_fifo.push_back(lag);
    if (exp >= 0) exp_sample.push_back(exp);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    int quiet = 0;
    while (quiet < 10 && n < budget) begin
      @(negedge clk);
      n++;
      if (song_fifo.size() == 0 && ref_fifo.size() == 0 && s_wait == 0 && r_wait == 0)
        quiet++;
      else
        quiet = 0;
    end
    checks++;
    if (quiet < 10) begin
      errors++;
      $display("FAIL drain: got %0d cycles busy expected idle within %0d", n, budget);
    end
  endtask

  // FIFO model: data/valid presented during the cycle after rd_en, held over the sampling edge.
  initial begin
    forever begin
      @(negedge clk);
      song_valid = 1'b0;
      ref_valid  = 1'b0;
      if (s_wait > 0) begin
        s_wait--;
        if (s_wait == 0) begin song_dout = s_hold; song_valid = 1'b1; end
      end
      if (r_wait > 0) begin
        r_wait--;
        if (r_wait == 0) begin ref_dout = r_hold; ref_valid = 1'b1; end
      end
      if (song_rd_en || ref_rd_en) begin
        check("rd_en_pairing", int'(song_rd_en), int'(ref_rd_en));
        if (song_rd_en) begin
          rd_song++;
          if (song_fifo.size() == 0) check("song_pop_empty", 1, 0);
          else begin s_hold = song_fifo.pop_front(); s_wait = 1; end
        end
        if (ref_rd_en) begin
          rd_ref++;
          if (ref_fifo.size() == 0) check("ref_pop_empty", 1, 0);
          else begin
            int lag;
            r_hold = ref_fifo.pop_front();
            lag = lag_fifo.pop_front();
            r_wait = (lag >= 7) ? 0 : 1 + lag;
          end
        end
      end
      song_empty = (song_fifo.size() == 0);
      ref_empty  = (ref_fifo.size() == 0);
    end
  end

  // Sample monitor: once both valids of a pair have been seen, the score lands two cycles later.
  initial begin
    bit gs = 1'b0, gr = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (song_rd_en) begin gs = 1'b0; gr = 1'b0; end
      if (song_valid) gs = 1'b1;
      if (ref_valid)  gr = 1'b1;
      if (gs && gr) begin
        gs = 1'b0; gr = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        if (exp_sample.size() == 0) check("unexpected_sample", int'(sample_score), -1);
        else check("sample_score", int'(sample_score), exp_sample.pop_front());
      end
    end
  end

  // Average monitor
  initial begin
    forever begin
      @(negedge clk); #1;
      if (score_ready) begin
        if (exp_avg.size() == 0) check("unexpected_score_ready", int'(score_avg), -1);
        else check("score_avg", int'(score_avg), exp_avg.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rd_en"},        int'(song_rd_en | ref_rd_en), 0);
    check({tag, "_sample_score"}, int'(sample_score), 0);
    check({tag, "_score_avg"},    int'(score_avg), 0);
    check({tag, "_score_ready"},  int'(score_ready), 0);
    check({tag, "_sync_err"},     int'(sync_err), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    score_en = 1'b1;

    // Window 1: perfect match
    rd_song = 0; rd_ref = 0;
    for (int i = 0; i < 16; i++) send(440, 440, 0, 15);
    exp_avg.push_back(15);
    drain(400);
    check("w1_song_pops", rd_song, 16);
    check("w1_ref_pops", rd_ref, 16);

    // Window 2: 8x15 + 8x10 = 200 -> 12, ref valid lagging 0..3 cycles
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 1) send(466, 440, i % 4, 10);
      else            send(441, 440, i % 4, 15);
    end
    exp_avg.push_back(12);
    drain(600);

    // Window 3: edge cases, one-sided empty FIFO, dropped pair; sum 146 -> 9
    send(1000, 440, 0, 0);
    send(0,    0,   0, 15);
    send(0,    3,   0, 0);
    send(2,    0,   0, 0);
    send(444,  440, 0, 15);
    send(445,  440, 0, 15);
    send(448,  440, 0, 14);
    send(440,  504, 0, 0);
    send(440,  503, 0, 1);
    drain(400);

    rd_song = 0; rd_ref = 0;
    song_fifo.push_back(15'd460);
    song_fifo.push_back(15'd470);
    song_fifo.push_back(15'd480);
    repeat (20) @(negedge clk);
    check("lone_song_no_song_pop", rd_song, 0);
    check("lone_song_no_ref_pop", rd_ref, 0);
    ref_fifo.push_back(15'd440); lag_fifo.push_back(0); exp_sample.push_back(11);
    repeat (20) @(negedge clk);
    check("one_ref_song_pops", rd_song, 1);
    check("one_ref_ref_pops", rd_ref, 1);
    ref_fifo.push_back(15'd440); lag_fifo.push_back(0); exp_sample.push_back(9);
    ref_fifo.push_back(15'd440); lag_fifo.push_back(0); exp_sample.push_back(6);
    drain(400);

    check("sync_err_before_drop", int'(sync_err), 0);
    send(440, 440, 7, -1);
    for (int i = 0; i < 4; i++) send(440, 440, 0, 15);
    exp_avg.push_back(9);
    drain(400);
    check("sync_err_after_drop", int'(sync_err), 1);

    // Window 4: reset after 9 pairs discards the partial window
    for (int i = 0; i < 9; i++) send(440, 440, 0, 15);
    drain(400);
    @(negedge clk);
    rst = 1'b1;
    #1 check_zero_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) send(466, 440, 0, 10);
    exp_avg.push_back(10);
    drain(400);

    check("samples_outstanding", exp_sample.size(), 0);
    check("averages_outstanding", exp_avg.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pitch_score_reader.md
# pitch_score_reader

Read-side consumer for the song and reference pitch FIFOs. Pops the sung frequency and the reference frequency in lockstep and converts each pair into a 4-bit closeness score. Averages the scores over a fixed window and publishes the result as `score_avg` with a one-cycle `score_ready` strobe. Sits between the two FIFO read ports and the score display/feedback logic in the top level.

## Interface
- `TOL_HZ`, 4: absolute frequency difference (Hz) that still earns a full score of 15.
- `STEP_SHIFT`, 2: each 2^STEP_SHIFT Hz beyond `TOL_HZ` costs one score point.
- `WINDOW_LOG2`, 4: the averaging window is 2^WINDOW_LOG2 sample pairs.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `score_en` input 1: when high, the block may pop the FIFOs.
- `song_empty` input 1: song FIFO empty flag.
- `song_dout` input 15: song FIFO read data (Hz).
- `song_valid` input 1: song FIFO read-data valid.
- `song_rd_en` output 1: song FIFO read enable.
- `ref_empty` input 1: reference FIFO empty flag.
- `ref_dout` input 15: reference FIFO read data (Hz).
- `ref_valid` input 1: reference FIFO read-data valid.
- `ref_rd_en` output 1: reference FIFO read enable.
- `sample_score` output 4: score of the most recent pair.
- `score_avg` output 4: average of the last completed window.
- `score_ready` output 1: one-cycle pulse when `score_avg` updates.
- `sync_err` output 1: sticky flag set when the FIFO valids fail to pair up.

## Operation
- FSM states: IDLE, FETCH, CAPTURE, ACCUM, PUBLISH.
- **IDLE**: go to FETCH when `score_en` is high and both `song_empty` and `ref_empty` are low. Otherwise stay.
- **FETCH**: `song_rd_en` and `ref_rd_en` are both high for exactly this one cycle. Next state is CAPTURE.
- **CAPTURE**
  - Latch `song_dout` on `song_valid` and `ref_dout` on `ref_valid`, each independently with its own got-flag.
  - Go to ACCUM once both got-flags are set. The valids may arrive in the same cycle or in different cycles.
  - If both flags are not set after 4 cycles in CAPTURE, set `sync_err`, discard the partial pair and return to IDLE.
- **Score computation** (combinational from the latched pair):
  - diff = |song - ref|, 15-bit unsigned.
  - If diff <= `TOL_HZ`, score = 15.
  - Otherwise pen = (diff - `TOL_HZ`) >> `STEP_SHIFT`, and score = 0 if pen >= 15, else 15 - pen.
  - Silence rule, which overrides the above: song = 0 and ref = 0 gives 15; exactly one of them 0 gives 0.
- **ACCUM**
  - `sample_score` <= score.
  - sum <= sum + score. The accumulator is 4+`WINDOW_LOG2` bits and cannot overflow.
  - cnt <= cnt + 1, where cnt is `WINDOW_LOG2` bits wide.
  - If cnt was 2^WINDOW_LOG2 - 1, go to PUBLISH; otherwise go to IDLE.
- **PUBLISH**
  - `score_avg` <= sum >> `WINDOW_LOG2` (truncating).
  - `score_ready` = 1 for this cycle.
  - sum <= 0 and cnt <= 0 (wrap).
  - Next state is IDLE.
- `score_en` falling mid-pair does not abort the pair; it only blocks the next FETCH from IDLE.
- `sync_err` clears only on `rst`.

## Timing
- Reset values: state IDLE, `song_rd_en`=0, `ref_rd_en`=0, `sample_score`=0, `score_avg`=0, `score_ready`=0, `sync_err`=0, sum=0, cnt=0.
- Reset mid-window discards the partial sum. Reset mid-FETCH drops `rd_en` immediately.
- FIFO read latency is 1 cycle: data and valid appear the cycle after `rd_en`.
- Nominal pair sequence:
  - cycle N: IDLE sees both FIFOs non-empty.
  - N+1: FETCH.
  - N+2: CAPTURE, valids arrive.
  - N+3: ACCUM.
  - N+4: IDLE or PUBLISH.
- Maximum throughput is one pair per 4 cycles. The last pair of a window takes 5 cycles, including PUBLISH.
- `score_avg` updates on the same edge that raises `score_ready` and holds until the next PUBLISH.
- `rd_en` is never asserted while the corresponding empty flag was high in the deciding IDLE cycle. Both read enables are always asserted together.
- If one FIFO is empty and the other is not, nothing is popped and the block waits in IDLE indefinitely.

## Test plan
- Reset, then write 16 pairs of song=440 / ref=440 -> every `sample_score`=15; one `score_ready` pulse; `score_avg`=15; exactly 16 `rd_en` pulses on each port.
- Pair song=466 / ref=440 (diff 26, pen 5) -> `sample_score`=10. Pair song=441 / ref=440 -> 15. Pair song=1000 / ref=440 -> 0.
- Window of 8 pairs scoring 15 and 8 pairs scoring 10 -> `score_avg`=12 (200>>4, truncating).
- Song FIFO holds 3 entries and ref FIFO is empty -> no `rd_en` on either port. After one ref write -> exactly one pop on each port.
- Force `ref_valid` to stay low after a FETCH -> `sync_err`=1 after 4 CAPTURE cycles; the block returns to IDLE; cnt is unchanged.
- Assert `rst` after 9 pairs -> all outputs return to 0; the next 16 pairs produce the first `score_ready`.
